// File: rtl/clock_pkg.sv
// Shared constants for the clock display: digit slots, separators and segment codes.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package clock_pkg;

    localparam int NUM_DIGITS = 6;

    typedef enum logic [2:0] {
        DIG_S1  = 3'd0,
        DIG_S10 = 3'd1,
        DIG_M1  = 3'd2,
        DIG_M10 = 3'd3,
        DIG_H1  = 3'd4,
        DIG_H10 = 3'd5
    } digit_e;

    localparam logic [NUM_DIGITS-1:0] SEP_MASK = 6'b010100;

    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_lut(input logic [3:0] code);
        logic [6:0] s;
        s = SEG_BLANK;
        unique case (code)
            4'd0:      s = 7'b1000000;
            4'd1:      s = 7'b1111001;
            4'd2:      s = 7'b0100100;
            4'd3:      s = 7'b0110000;
            4'd4:      s = 7'b0011001;
            4'd5:      s = 7'b0010010;
            4'd6:      s = 7'b0000010;
            4'd7:      s = 7'b1111000;
            4'd8:      s = 7'b0000000;
            4'd9:      s = 7'b0010000;
            CODE_DASH: s = SEG_DASH;
            default:   s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit code to active-low seven-segment decoder.
// Codes 0-9 are digits, CODE_DASH is a dash, anything else is blank.
module seg7_decoder
    import clock_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = seg_lut(code_i);
    end

endmodule

// File: rtl/display_scanner.sv
// Six-digit multiplexed HH:MM:SS scanner with frame snapshot, blink and blank.
// Outputs are registered and reflect the scan state of the previous clock.
module display_scanner
    import clock_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hr,
    input  logic       alarm_flag,
    input  logic       timer_done,
    input  logic       blank,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [7:0] BLINK_MAX = 8'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    digit_e           idx_q, idx_d;
    logic [5:0]       ssec_q, ssec_d;
    logic [5:0]       smin_q, smin_d;
    logic [4:0]       shr_q, shr_d;
    logic [7:0]       bcnt_q, bcnt_d;
    logic             bon_q, bon_d;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic       tick;
    logic       wrap;
    logic       active;
    logic       dark;
    logic [5:0] fval;
    logic       fbad;
    logic       tens;
    logic [3:0] bcd_t;
    logic [3:0] bcd_o;
    logic [3:0] code;
    logic [6:0] dec_seg;

    assign tick   = (pre_q == PRE_MAX);
    assign wrap   = tick && (idx_q == DIG_H10);
    assign active = alarm_flag | timer_done;
    assign dark   = blank | (active & ~bon_q);

    always_comb begin
        fval = 6'd0;
        fbad = 1'b0;
        tens = 1'b0;
        unique case (idx_q)
            DIG_S1:  begin fval = ssec_q; fbad = ssec_q > 6'd59; end
            DIG_S10: begin fval = ssec_q; fbad = ssec_q > 6'd59; tens = 1'b1; end
            DIG_M1:  begin fval = smin_q; fbad = smin_q > 6'd59; end
            DIG_M10: begin fval = smin_q; fbad = smin_q > 6'd59; tens = 1'b1; end
            DIG_H1:  begin fval = {1'b0, shr_q}; fbad = shr_q > 5'd23; end
            DIG_H10: begin fval = {1'b0, shr_q}; fbad = shr_q > 5'd23; tens = 1'b1; end
            default: begin fval = 6'd0; fbad = 1'b1; end
        endcase
    end

    assign bcd_t = 4'(fval / 6'd10);
    assign bcd_o = 4'(fval % 6'd10);

    always_comb begin
        code = tens ? bcd_t : bcd_o;
        if (fbad) code = CODE_DASH;
        if (dark) code = CODE_BLANK;
    end

    seg7_decoder u_dec (
        .code_i (code),
        .seg_o  (dec_seg)
    );

    always_comb begin
        pre_d  = tick ? '0 : pre_q + 1'b1;
        idx_d  = idx_q;
        ssec_d = ssec_q;
        smin_d = smin_q;
        shr_d  = shr_q;
        bcnt_d = bcnt_q;
        bon_d  = bon_q;
        if (tick) begin
            unique case (idx_q)
                DIG_S1:  idx_d = DIG_S10;
                DIG_S10: idx_d = DIG_M1;
                DIG_M1:  idx_d = DIG_M10;
                DIG_M10: idx_d = DIG_H1;
                DIG_H1:  idx_d = DIG_H10;
                default: idx_d = DIG_S1;
            endcase
        end
        if (wrap) begin
            ssec_d = sec;
            smin_d = min;
            shr_d  = hr;
        end
        // Idle clears immediately; blink counts frames only while requested.
        if (!active) begin
            bcnt_d = 8'd0;
            bon_d  = 1'b1;
        end else if (wrap) begin
            if (bcnt_q >= BLINK_MAX) begin
                bcnt_d = 8'd0;
                bon_d  = ~bon_q;
            end else begin
                bcnt_d = bcnt_q + 8'd1;
            end
        end
        an_d  = dark ? 6'b111111 : ~(6'd1 << idx_q);
        seg_d = dec_seg;
        dp_d  = dark | ~SEP_MASK[idx_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            idx_q  <= DIG_S1;
            ssec_q <= 6'd0;
            smin_q <= 6'd0;
            shr_q  <= 5'd0;
            bcnt_q <= 8'd0;
            bon_q  <= 1'b1;
            an_q   <= 6'b111111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            ssec_q <= ssec_d;
            smin_q <= smin_d;
            shr_q  <= shr_d;
            bcnt_q <= bcnt_d;
            bon_q  <= bon_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
